// File: rtl/float_mul_seq.sv
// float_mul_seq: multi-cycle IEEE-754 single-precision multiplier.
// The significand product is accumulated one multiplier bit per cycle by a
// shift-add datapath, then normalised and rounded to nearest-even in one cycle.
module float_mul_seq #(
    parameter int MANT_W = 24,
    parameter int BIAS   = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] S,
    output logic        ERR,
    output logic        busy,
    output logic        done
);

    localparam int ACC_W  = 2 * MANT_W;
    localparam int FRAC_W = MANT_W - 1;
    localparam int CNT_W  = $clog2(MANT_W);
    localparam logic signed [9:0] BIAS_S = 10'(BIAS);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} stateT;

    stateT              state;
    logic [MANT_W-1:0]  mantA;
    logic [MANT_W-1:0]  mantB;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic signed [9:0]  expSum;
    logic               sign;

    logic [7:0]         aExp;
    logic [7:0]         bExp;
    logic [FRAC_W-1:0]  aFrac;
    logic [FRAC_W-1:0]  bFrac;
    logic               aZero;
    logic               bZero;
    logic               aInf;
    logic               bInf;
    logic               aNan;
    logic               bNan;
    logic               opSign;
    logic               anyNan;
    logic               anyInf;
    logic               anyZero;
    logic signed [9:0]  expStart;

    logic               normHi;
    logic [FRAC_W-1:0]  fracRaw;
    logic               guardBit;
    logic               stickyBit;
    logic               roundUp;
    logic [FRAC_W:0]    fracRounded;
    logic signed [9:0]  expNorm;

    // Operand classification; denormals are treated as zero.
    assign aExp    = A[30:23];
    assign bExp    = B[30:23];
    assign aFrac   = A[FRAC_W-1:0];
    assign bFrac   = B[FRAC_W-1:0];
    assign aZero   = (aExp == 8'h00);
    assign bZero   = (bExp == 8'h00);
    assign aInf    = (aExp == 8'hFF) && (aFrac == '0);
    assign bInf    = (bExp == 8'hFF) && (bFrac == '0);
    assign aNan    = (aExp == 8'hFF) && (aFrac != '0);
    assign bNan    = (bExp == 8'hFF) && (bFrac != '0);
    assign opSign  = A[31] ^ B[31];
    assign anyNan  = aNan | bNan | (aInf & bZero) | (bInf & aZero);
    assign anyInf  = aInf | bInf;
    assign anyZero = aZero | bZero;
    assign expStart = $signed({2'b00, aExp}) + $signed({2'b00, bExp}) - BIAS_S;

    // Normalise the raw product, pick guard/sticky and round to nearest even.
    always_comb begin
        normHi = acc[ACC_W-1];
        if (normHi) begin
            fracRaw   = acc[ACC_W-2 -: FRAC_W];
            guardBit  = acc[ACC_W-2-FRAC_W];
            stickyBit = |acc[ACC_W-3-FRAC_W:0];
        end else begin
            fracRaw   = acc[ACC_W-3 -: FRAC_W];
            guardBit  = acc[ACC_W-3-FRAC_W];
            stickyBit = |acc[ACC_W-4-FRAC_W:0];
        end
        roundUp     = guardBit & (stickyBit | fracRaw[0]);
        fracRounded = {1'b0, fracRaw} + {{FRAC_W{1'b0}}, roundUp};
        expNorm     = expSum + {9'b0, normHi} + {9'b0, fracRounded[FRAC_W]};
    end

    // Control FSM with registered outputs and the shift-add datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            S      <= 32'h0;
            ERR    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            mantA  <= '0;
            mantB  <= '0;
            expSum <= '0;
            sign   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign <= opSign;
                        if (anyNan) begin
                            S     <= QNAN;
                            ERR   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (anyInf) begin
                            S     <= {opSign, 8'hFF, 23'h0};
                            ERR   <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (anyZero) begin
                            S     <= {opSign, 31'h0};
                            ERR   <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            mantA  <= {1'b1, aFrac};
                            mantB  <= {1'b1, bFrac};
                            acc    <= '0;
                            cnt    <= '0;
                            expSum <= expStart;
                            busy   <= 1'b1;
                            state  <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (mantB[cnt]) begin
                        acc <= acc + ({{MANT_W{1'b0}}, mantA} << cnt);
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(MANT_W - 1)) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (expNorm >= 10'sd255) begin
                        S   <= {sign, 8'hFF, 23'h0};
                        ERR <= 1'b1;
                    end else if (expNorm <= 10'sd0) begin
                        S   <= {sign, 31'h0};
                        ERR <= 1'b0;
                    end else begin
                        S   <= {sign, expNorm[7:0], fracRounded[FRAC_W-1:0]};
                        ERR <= 1'b0;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_mul_seq.sv
// tb_float_mul_seq: scoreboard bench for the sequential float multiplier.
// Stimulus pushes expected results; a negedge monitor pops and compares on done.
module tb_float_mul_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = 32'h0;
    logic [31:0] B = 32'h0;
    logic [31:0] S;
    logic        ERR;
    logic        busy;
    logic        done;

    float_mul_seq #(.MANT_W(24), .BIAS(127)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .A(A),
        .B(B),
        .S(S),
        .ERR(ERR),
        .busy(busy),
        .done(done)
    );

    typedef struct {
        logic [31:0] s;
        logic        err;
        bit          special;
    } refT;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic        err;
        int          doneCyc;
        int          busyCyc;
    } expT;

    expT expQ[$];
    int  cycCount = 0;
    int  busyCount = 0;
    int  testsRun = 0;
    int  testsFailed = 0;

    // Free-running clock.
    initial forever #5 clk = ~clk;

    // Count rising edges so latency can be measured in cycles.
    initial forever begin
        @(posedge clk);
        cycCount = cycCount + 1;
    end

    // Product computed from the IEEE rules with plain integer arithmetic.
    function automatic refT refModel(input logic [31:0] a, input logic [31:0] b);
        refT r;
        logic sgn;
        int ea, eb, e, sh;
        longint unsigned fa, fb, p, q, rem, half;
        bit aZ, bZ, aI, bI, aN, bN;
        sgn = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = longint'(a[22:0]);
        fb = longint'(b[22:0]);
        aZ = (ea == 0);
        bZ = (eb == 0);
        aI = (ea == 255) && (fa == 0);
        bI = (eb == 255) && (fb == 0);
        aN = (ea == 255) && (fa != 0);
        bN = (eb == 255) && (fb != 0);
        r.special = 1'b1;
        if (aN || bN || (aI && bZ) || (bI && aZ)) begin
            r.s = 32'h7FC00000;
            r.err = 1'b1;
        end else if (aI || bI) begin
            r.s = {sgn, 8'hFF, 23'h0};
            r.err = 1'b0;
        end else if (aZ || bZ) begin
            r.s = {sgn, 31'h0};
            r.err = 1'b0;
        end else begin
            r.special = 1'b0;
            p = (fa + 64'd8388608) * (fb + 64'd8388608);
            e = ea + eb - 127;
            sh = 23;
            if (p >= (64'd1 << 47)) begin
                sh = 24;
                e = e + 1;
            end
            q = p >> sh;
            rem = p - (q << sh);
            half = 64'd1 << (sh - 1);
            if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= 255) begin
                r.s = {sgn, 8'hFF, 23'h0};
                r.err = 1'b1;
            end else if (e <= 0) begin
                r.s = {sgn, 31'h0};
                r.err = 1'b0;
            end else begin
                r.s = {sgn, 8'(e), q[22:0]};
                r.err = 1'b0;
            end
        end
        return r;
    endfunction

    // Random operand mixing ordinary values, range extremes and specials.
    function automatic logic [31:0] randOperand();
        logic [31:0] sp[6];
        int sel;
        sp[0] = 32'h00000000;
        sp[1] = 32'h80000000;
        sp[2] = 32'h7F800000;
        sp[3] = 32'hFF800000;
        sp[4] = 32'h7FC00000;
        sp[5] = 32'h00400000;
        sel = int'($urandom_range(0, 9));
        if (sel == 0) return sp[$urandom_range(0, 5)];
        if (sel == 1) return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        return {1'($urandom), 8'($urandom_range(60, 190)), 23'($urandom)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun = testsRun + 1;
        if (actual !== expected) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Issue one operation; caller is just after a rising edge with the DUT idle.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expS, input logic expErr, input bit special);
        expT e;
        e.a = a;
        e.b = b;
        e.s = expS;
        e.err = expErr;
        e.doneCyc = cycCount + (special ? 1 : 26);
        e.busyCyc = special ? 0 : 25;
        A = a;
        B = b;
        start = 1'b1;
        expQ.push_back(e);
        @(posedge clk);
        #2;
        start = 1'b0;
        A = $urandom;
        B = $urandom;
    endtask

    task automatic applyModel(input logic [31:0] a, input logic [31:0] b);
        refT r;
        r = refModel(a, b);
        applyStimulus(a, b, r.s, r.err, r.special);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 100; i++) begin
            if (expQ.size() == 0) break;
            @(posedge clk);
            #2;
        end
        if (expQ.size() != 0) begin
            testsRun = testsRun + 1;
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL done timeout: got %0d pending results, expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    // Monitor: compare every presented result against the scoreboard head.
    initial forever begin
        expT e;
        @(negedge clk);
        if (rst) begin
            busyCount = 0;
        end else if (done) begin
            if (expQ.size() == 0) begin
                testsRun = testsRun + 1;
                testsFailed = testsFailed + 1;
                $display("[TB] FAIL unexpected done: got S=%h ERR=%b, expected no result", S, ERR);
            end else begin
                e = expQ.pop_front();
                checkOutput($sformatf("S for %h*%h", e.a, e.b), S, e.s);
                checkOutput($sformatf("ERR for %h*%h", e.a, e.b), 32'(ERR), 32'(e.err));
                checkOutput($sformatf("done cycle for %h*%h", e.a, e.b), 32'(cycCount), 32'(e.doneCyc));
                checkOutput($sformatf("busy cycles for %h*%h", e.a, e.b), 32'(busyCount), 32'(e.busyCyc));
            end
            busyCount = 0;
        end else if (busy) begin
            busyCount = busyCount + 1;
        end
    end

    // Main stimulus sequence.
    initial begin
        expT e;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset S", S, 32'h0);
        checkOutput("reset ERR", 32'(ERR), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset done", 32'(done), 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        applyStimulus(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0); waitIdle();
        applyStimulus(32'h3FC00000, 32'hC0000000, 32'hC0400000, 1'b0, 1'b0); waitIdle();
        applyStimulus(32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0); waitIdle();
        applyStimulus(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0, 1'b0); waitIdle();
        applyStimulus(32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b1); waitIdle();
        applyStimulus(32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b1); waitIdle();
        applyStimulus(32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0); waitIdle();
        applyStimulus(32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b0); waitIdle();

        // A second start while busy must not disturb the running operation.
        applyStimulus(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #2;
        end
        A = 32'h3F800001;
        B = 32'hC1200000;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        waitIdle();

        // Reset in the middle of an operation aborts it without a done.
        applyStimulus(32'h40400000, 32'h40400000, 32'h41100000, 1'b0, 1'b0);
        repeat (11) begin
            @(posedge clk);
            #2;
        end
        rst = 1'b1;
        expQ.delete();
        @(posedge clk);
        @(negedge clk);
        checkOutput("busy after reset", 32'(busy), 32'h0);
        checkOutput("S after reset", S, 32'h0);
        checkOutput("done after reset", 32'(done), 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #2;
        end
        applyStimulus(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0); waitIdle();

        // start held high gives back-to-back operations every 27 cycles.
        A = 32'h40000000;
        B = 32'h40400000;
        start = 1'b1;
        e = '{a: 32'h40000000, b: 32'h40400000, s: 32'h40C00000, err: 1'b0, doneCyc: cycCount + 26, busyCyc: 25};
        expQ.push_back(e);
        e = '{a: 32'h3FC00000, b: 32'hC0000000, s: 32'hC0400000, err: 1'b0, doneCyc: cycCount + 53, busyCyc: 25};
        expQ.push_back(e);
        @(posedge clk);
        #2;
        A = 32'h3FC00000;
        B = 32'hC0000000;
        repeat (27) begin
            @(posedge clk);
            #2;
        end
        start = 1'b0;
        waitIdle();

        for (int i = 0; i < 40; i++) begin
            applyModel(randOperand(), randOperand());
            waitIdle();
        end

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
